// File: rtl/robo_pkg.sv
// Shared encodings for the wall-follower robot: headings, move commands and FSM states.
package robo_pkg;

  // Heading codes as seen on orientacao.
  localparam logic [2:0] OR_N = 3'b001;
  localparam logic [2:0] OR_W = 3'b010;
  localparam logic [2:0] OR_E = 3'b011;
  localparam logic [2:0] OR_S = 3'b100;

  // Move command codes as seen on acao.
  localparam logic [2:0] ACT_NONE = 3'b000;
  localparam logic [2:0] ACT_N    = 3'b001;
  localparam logic [2:0] ACT_W    = 3'b010;
  localparam logic [2:0] ACT_S    = 3'b011;
  localparam logic [2:0] ACT_E    = 3'b100;

  localparam logic [2:0] TURN_LIMIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECIDE = 3'd2,
    ST_MOVE   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Command that moves one cell in the direction of the given heading.
  function automatic logic [2:0] fwd_act(input logic [2:0] heading);
    logic [2:0] act;
    case (heading)
      OR_N:    act = ACT_N;
      OR_W:    act = ACT_W;
      OR_S:    act = ACT_S;
      OR_E:    act = ACT_E;
      default: act = ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/robo_dir_lut.sv
// Combinational heading table: left/right neighbours, forward command and the
// forward command of the left neighbour (used by turn-left-and-move).
module robo_dir_lut
  import robo_pkg::*;
(
  input  logic [2:0] heading,
  output logic [2:0] left_heading,
  output logic [2:0] right_heading,
  output logic [2:0] fwd_cmd,
  output logic [2:0] left_fwd_cmd
);

  always_comb begin
    left_heading  = OR_N;
    right_heading = OR_N;
    case (heading)
      OR_N: begin left_heading = OR_W; right_heading = OR_E; end
      OR_W: begin left_heading = OR_S; right_heading = OR_N; end
      OR_S: begin left_heading = OR_E; right_heading = OR_W; end
      OR_E: begin left_heading = OR_N; right_heading = OR_S; end
      default: begin left_heading = OR_N; right_heading = OR_N; end
    endcase
  end

  assign fwd_cmd      = fwd_act(heading);
  assign left_fwd_cmd = fwd_act(left_heading);

endmodule

// File: rtl/robo_wall_follower.sv
// Left-hand wall follower: WAIT -> DECIDE -> (MOVE | turn right) loop until the
// exit is reached, the move budget runs out, or four right turns find no way out.
module robo_wall_follower
  import robo_pkg::*;
#(
  parameter logic [7:0]  START_ROW = 8'd11,
  parameter logic [7:0]  START_COL = 8'd1,
  parameter logic [7:0]  EXIT_ROW  = 8'd0,
  parameter logic [7:0]  EXIT_COL  = 8'd20,
  parameter logic [15:0] MAX_STEPS = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        head,
  input  logic        left,
  output logic [2:0]  acao,
  output logic [2:0]  orientacao,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [15:0] step_cnt,
  output logic [7:0]  linha,
  output logic [7:0]  coluna,
  output logic [2:0]  fsm_state
);

  state_t      state_q,  state_d;
  logic [2:0]  acao_q,   acao_d;
  logic [2:0]  orient_q, orient_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic        found_q,  found_d;
  logic [15:0] step_q,   step_d;
  logic [2:0]  turn_q,   turn_d;
  logic [7:0]  linha_q,  linha_d;
  logic [7:0]  coluna_q, coluna_d;

  logic [2:0] left_heading, right_heading, fwd_cmd, left_fwd_cmd;

  robo_dir_lut u_dir_lut (
    .heading      (orient_q),
    .left_heading (left_heading),
    .right_heading(right_heading),
    .fwd_cmd      (fwd_cmd),
    .left_fwd_cmd (left_fwd_cmd)
  );

  always_comb begin
    state_d  = state_q;
    acao_d   = ACT_NONE;
    orient_d = orient_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    step_d   = step_q;
    turn_d   = turn_q;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: state_d = ST_DECIDE;
      ST_DECIDE: begin
        if (linha_q == EXIT_ROW && coluna_q == EXIT_COL) begin
          state_d = ST_DONE;
          found_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (step_q == MAX_STEPS || turn_q == TURN_LIMIT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (!left) begin
          orient_d = left_heading;
          acao_d   = left_fwd_cmd;
          state_d  = ST_MOVE;
        end else if (!head) begin
          acao_d  = fwd_cmd;
          state_d = ST_MOVE;
        end else begin
          orient_d = right_heading;
          turn_d   = (turn_q == TURN_LIMIT) ? TURN_LIMIT : turn_q + 3'd1;
          state_d  = ST_WAIT;
        end
      end
      ST_MOVE: begin
        // Position follows the command that was on acao during this cycle.
        case (acao_q)
          ACT_N:   linha_d  = linha_q - 8'd1;
          ACT_W:   coluna_d = coluna_q - 8'd1;
          ACT_S:   linha_d  = linha_q + 8'd1;
          ACT_E:   coluna_d = coluna_q + 8'd1;
          default: ;
        endcase
        step_d  = step_q + 16'd1;
        turn_d  = 3'd0;
        state_d = ST_WAIT;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acao_q   <= ACT_NONE;
      orient_q <= OR_N;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      step_q   <= 16'd0;
      turn_q   <= 3'd0;
      linha_q  <= START_ROW;
      coluna_q <= START_COL;
    end else begin
      state_q  <= state_d;
      acao_q   <= acao_d;
      orient_q <= orient_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      step_q   <= step_d;
      turn_q   <= turn_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
    end
  end

  assign acao       = acao_q;
  assign orientacao = orient_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign step_cnt   = step_q;
  assign linha      = linha_q;
  assign coluna     = coluna_q;
  assign fsm_state  = state_q;

endmodule
